// File: rtl/alu_8bit_pkg.sv
// alu_8bit_pkg: shared constants for the 8-bit add/subtract unit.
//   ALU_WIDTH : default operand/result width
//   OP_ADD    : value of the sub input selecting addition
//   OP_SUB    : value of the sub input selecting subtraction
package alu_8bit_pkg;

    localparam int   ALU_WIDTH = 8;
    localparam logic OP_ADD    = 1'b0;
    localparam logic OP_SUB    = 1'b1;

endpackage : alu_8bit_pkg

// File: rtl/alu_flags_reg.sv
// alu_flags_reg: 2-bit carry/zero flags register with capture enable and
// asynchronous active-high clear.
//   clk      : capture clock (rising edge)
//   clr      : async clear, forces cf/zf to 0 and wins over a clock edge
//   en       : capture enable; flags hold when low (or unknown)
//   carry_in : carry to capture
//   zero_in  : zero to capture
//   cf, zf   : registered flags
module alu_flags_reg (
    input  logic clk,
    input  logic clr,
    input  logic en,
    input  logic carry_in,
    input  logic zero_in,
    output logic cf,
    output logic zf
);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            // NOTE: non-blocking assignments in clocked logic so every
            // flop samples pre-edge values regardless of statement order.
            cf <= 1'b0;
            zf <= 1'b0;
        end else if (en) begin
            cf <= carry_in;
            zf <= zero_in;
        end
    end

endmodule : alu_flags_reg

// File: rtl/alu_8bit.sv
// alu_8bit: add/subtract unit for the 8-bit computer datapath.
// The result drives the shared bus only while sumout is high; carry and
// zero are captured into a flags register on the same enable so the
// control unit can branch on them.
//   out    : result to bus, high-Z unless sumout=1
//   cf     : registered carry (add: unsigned overflow, sub: 1 = no borrow)
//   zf     : registered zero
//   a, b   : operands from the A and B registers
//   clk    : clock, flags update on rising edge
//   sumout : bus output enable and flag-capture enable
//   sub    : 0 = add, 1 = subtract
//   clr    : async active-high clear of the flags
module alu_8bit
    import alu_8bit_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    output logic [WIDTH-1:0] out,
    output logic             cf,
    output logic             zf,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clk,
    input  logic             sumout,
    input  logic             sub,
    input  logic             clr
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;
    logic             drive;

    // Subtraction is a + ~b + 1; the +1 comes in as the carry-in, so the
    // top sum bit reads directly as "no borrow" when subtracting.
    always_comb begin
        // NOTE: defaults first so no path through the block can leave a
        // variable unassigned and infer a latch.
        b_eff = b;
        if (sub == OP_SUB) begin
            b_eff = ~b;
        end
        sum = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    end

    assign result = sum[WIDTH-1:0];
    assign carry  = sum[WIDTH];
    assign zero   = (result == '0);

    // Case equality keeps an unknown enable from driving the bus in
    // simulation; synthesis treats it as a plain compare.
    assign drive = (sumout === 1'b1);
    assign out   = drive ? result : {WIDTH{1'bz}};

    alu_flags_reg u_flags (
        .clk      (clk),
        .clr      (clr),
        .en       (drive),
        .carry_in (carry),
        .zero_in  (zero),
        .cf       (cf),
        .zf       (zf)
    );

endmodule : alu_8bit

// File: tb/tb_alu_8bit.sv
// tb_alu_8bit: directed self-checking bench for alu_8bit using a
// scoreboard queue of expected bus values and flag pairs.
module tb_alu_8bit;

    typedef struct {
        string      tag;
        logic       is_flags;
        logic [7:0] val;
    } exp_t;

    logic       clk = 1'b0;
    logic       clr;
    logic [7:0] a;
    logic [7:0] b;
    logic       sumout;
    logic       sub;
    wire  [7:0] out;
    wire        cf;
    wire        zf;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    // Flag model state
    logic m_cf;
    logic m_zf;

    alu_8bit dut (
        .out    (out),
        .cf     (cf),
        .zf     (zf),
        .a      (a),
        .b      (b),
        .clk    (clk),
        .sumout (sumout),
        .sub    (sub),
        .clr    (clr)
    );

    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Reference: carry is unsigned overflow for add, a>=b for subtract.
    function automatic logic [1:0] model_cz(input logic [7:0] x,
                                            input logic [7:0] y,
                                            input logic       s);
        logic [8:0] wide;
        logic [7:0] r;
        logic       c;
        if (s) begin
            r = x - y;
            c = (x >= y);
        end else begin
            wide = {1'b0, x} + {1'b0, y};
            r    = wide[7:0];
            c    = wide[8];
        end
        return {c, (r == 8'h00)};
    endfunction

    function automatic logic [7:0] model_out(input logic [7:0] x,
                                             input logic [7:0] y,
                                             input logic       s,
                                             input logic       en);
        if (en !== 1'b1) return 8'bzzzz_zzzz;
        return s ? 8'(x - y) : 8'(x + y);
    endfunction

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input logic want_flags);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_empty: observed=empty expected=entry");
            return;
        end
        e = sb.pop_front();
        if (e.is_flags !== want_flags) begin
            checks++;
            errors++;
            $error("FAIL sb_order %s: observed=%b expected=%b",
                   e.tag, want_flags, e.is_flags);
            return;
        end
        if (want_flags) check(e.tag, {6'b0, cf, zf}, e.val);
        else            check(e.tag, out, e.val);
    endtask

    // Drive operands, queue the expected bus value, compare after settling.
    task automatic apply(input string tag, input logic [7:0] x,
                         input logic [7:0] y, input logic s,
                         input logic en);
        exp_t e;
        a      = x;
        b      = y;
        sub    = s;
        sumout = en;
        e.tag = {tag, "_out"};
        e.is_flags = 1'b0;
        e.val = model_out(x, y, s, en);
        sb.push_back(e);
        #1;
        pop_check(1'b0);
    endtask

    // Queue flags expected after the next edge, then clock and compare.
    task automatic tick(input string tag);
        exp_t e;
        if (clr) begin
            m_cf = 1'b0;
            m_zf = 1'b0;
        end else if (sumout === 1'b1) begin
            {m_cf, m_zf} = model_cz(a, b, sub);
        end
        e.tag = {tag, "_flags"};
        e.is_flags = 1'b1;
        e.val = {6'b0, m_cf, m_zf};
        sb.push_back(e);
        @(posedge clk);
        #1;
        pop_check(1'b1);
    endtask

    task automatic push_flags_now(input string tag);
        exp_t e;
        e.tag = tag;
        e.is_flags = 1'b1;
        e.val = {6'b0, m_cf, m_zf};
        sb.push_back(e);
    endtask

    initial begin
        // Reset: flags clear immediately, before any clock edge.
        clr = 1'b1;
        m_cf = 1'b0;
        m_zf = 1'b0;
        apply("rst", 8'h5A, 8'h33, 1'b0, 1'b0);
        push_flags_now("rst_flags_async");
        pop_check(1'b1);
        @(posedge clk);
        #1;
        clr = 1'b0;
        tick("rst_hold");

        // Add zero, then drop enable.
        apply("add0", 8'h00, 8'h00, 1'b0, 1'b1);
        tick("add0");
        apply("add0_off", 8'h00, 8'h00, 1'b0, 1'b0);
        tick("add0_off");

        // Subtract zero: no borrow.
        apply("sub0", 8'h00, 8'h00, 1'b1, 1'b1);
        tick("sub0");
        apply("sub0_off", 8'h00, 8'h00, 1'b0, 1'b0);
        tick("sub0_off");

        // Add wrap-around and signed-overflow-only case.
        apply("addwrap", 8'hFF, 8'h01, 1'b0, 1'b1);
        tick("addwrap");
        apply("add7f", 8'h7F, 8'h01, 1'b0, 1'b1);
        tick("add7f");

        // Subtract with and without borrow; sub toggles same cycle.
        apply("subbor", 8'h05, 8'h07, 1'b1, 1'b1);
        tick("subbor");
        apply("subnb_add", 8'h07, 8'h05, 1'b0, 1'b1);
        apply("subnb", 8'h07, 8'h05, 1'b1, 1'b1);
        tick("subnb");

        // Enable gating across several edges with changing operands.
        for (int i = 0; i < 4; i++) begin
            apply($sformatf("gate%0d", i), 8'($urandom), 8'($urandom),
                  1'($urandom), 1'b0);
            tick($sformatf("gate%0d", i));
        end

        // Unknown enable must neither drive the bus nor capture flags.
        apply("xen", 8'hFF, 8'h01, 1'b0, 1'bx);
        tick("xen");

        // Random operand patterns.
        for (int i = 0; i < 8; i++) begin
            apply($sformatf("rnd%0d", i), 8'($urandom), 8'($urandom),
                  1'($urandom), 1'b1);
            tick($sformatf("rnd%0d", i));
        end

        // Set both flags, then clear asynchronously mid-cycle.
        apply("pre_clr", 8'hFF, 8'h01, 1'b0, 1'b1);
        tick("pre_clr");
        apply("clr_out", 8'h03, 8'h04, 1'b0, 1'b1);
        #2;
        clr = 1'b1;
        m_cf = 1'b0;
        m_zf = 1'b0;
        #1;
        push_flags_now("clr_async");
        pop_check(1'b1);
        // Bus output is independent of clr.
        apply("clr_bus", 8'h03, 8'h04, 1'b0, 1'b1);
        clr = 1'b0;
        apply("post_clr_off", 8'h03, 8'h04, 1'b0, 1'b0);
        tick("post_clr");

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL sb_leftover: observed=%0d expected=0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_alu_8bit
